// File: rtl/nx_msg_distributor_pkg.sv
// ============================================================================
// Module   : nx_msg_distributor_pkg
// Purpose  : Shared direction type and direction count for the distributor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nx_msg_distributor_pkg;

    // Bit order matches the decoder's send-direction mask.
    typedef enum logic [1:0] {
        DIRX_NORTH = 2'd0,
        DIRX_EAST  = 2'd1,
        DIRX_SOUTH = 2'd2,
        DIRX_WEST  = 2'd3
    } nx_direction_t;

    localparam int NX_DIRECTIONS = 4;

endpackage

`default_nettype wire

// File: rtl/nx_msg_distributor_if.sv
// ============================================================================
// Module   : nx_msg_distributor_if
// Purpose  : Bypass/emit input streams and four-way outbound stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nx_msg_distributor_if #(
    parameter int STREAM_WIDTH = 32
);
    import nx_msg_distributor_pkg::*;

    logic [STREAM_WIDTH-1:0]               bypass_data_i;
    nx_direction_t                         bypass_dir_i;
    logic                                  bypass_valid_i;
    logic                                  bypass_ready_o;
    logic [STREAM_WIDTH-1:0]               emit_data_i;
    nx_direction_t                         emit_dir_i;
    logic                                  emit_valid_i;
    logic                                  emit_ready_o;
    logic [NX_DIRECTIONS*STREAM_WIDTH-1:0] dist_data_o;
    logic [NX_DIRECTIONS-1:0]              dist_valid_o;
    logic [NX_DIRECTIONS-1:0]              dist_ready_i;

    modport master (
        output bypass_data_i, bypass_dir_i, bypass_valid_i,
        output emit_data_i, emit_dir_i, emit_valid_i,
        output dist_ready_i,
        input  bypass_ready_o, emit_ready_o, dist_data_o, dist_valid_o
    );

    modport slave (
        input  bypass_data_i, bypass_dir_i, bypass_valid_i,
        input  emit_data_i, emit_dir_i, emit_valid_i,
        input  dist_ready_i,
        output bypass_ready_o, emit_ready_o, dist_data_o, dist_valid_o
    );

endinterface

`default_nettype wire

// File: rtl/nx_dist_port.sv
// ============================================================================
// Module   : nx_dist_port
// Purpose  : One outbound direction: output register, free logic and 2-way
//            bypass/emit arbiter. NX_DIST_ROUND_ROBIN_EN adds a toggling
//            priority pointer; otherwise bypass always wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nx_dist_port #(
    parameter int STREAM_WIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    byp_valid,
    input  wire logic                    byp_hit,
    input  wire logic [STREAM_WIDTH-1:0] byp_data,
    input  wire logic                    emit_valid,
    input  wire logic                    emit_hit,
    input  wire logic [STREAM_WIDTH-1:0] emit_data,
    input  wire logic                    out_ready,
    output logic                         byp_grant,
    output logic                         emit_grant,
    output logic [STREAM_WIDTH-1:0]      out_data,
    output logic                         out_valid
);

    logic                    r_valid;
    logic [STREAM_WIDTH-1:0] r_data;
    logic                    w_free;
    logic                    w_conflict;
    logic                    w_emit_favoured;
    logic                    w_load_byp;
    logic                    w_load_emit;

    assign w_free     = !r_valid || out_ready;
    assign w_conflict = byp_valid && byp_hit && emit_valid && emit_hit;

`ifdef NX_DIST_ROUND_ROBIN_EN
    logic r_ptr;

    // Pointer moves only when a real conflict is resolved, giving alternation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_free && w_conflict) begin
            r_ptr <= !r_ptr;
        end
    end

    assign w_emit_favoured = r_ptr;
`else
    assign w_emit_favoured = 1'b0;
`endif

    // Each grant looks only at the competing source's valid, never its own.
    assign byp_grant  = w_free && byp_hit  && !(emit_valid && emit_hit && w_emit_favoured);
    assign emit_grant = w_free && emit_hit && !(byp_valid && byp_hit && !w_emit_favoured);

    assign w_load_byp  = byp_valid && byp_grant;
    assign w_load_emit = emit_valid && emit_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_load_byp) begin
                r_data <= byp_data;
            end else if (w_load_emit) begin
                r_data <= emit_data;
            end
            if (w_load_byp || w_load_emit) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/nx_msg_distributor.sv
// ============================================================================
// Module   : nx_msg_distributor
// Purpose  : Merges decoder bypass and encoder emit streams and steers each
//            message to a registered N/E/S/W port. Optional round-robin
//            arbitration via NX_DIST_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nx_msg_distributor
    import nx_msg_distributor_pkg::*;
#(
    parameter int STREAM_WIDTH = 32
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    output logic                 idle_o,
    nx_msg_distributor_if.slave  bus
);

    logic [NX_DIRECTIONS-1:0] w_byp_grant;
    logic [NX_DIRECTIONS-1:0] w_emit_grant;

    generate
        for (genvar d = 0; d < NX_DIRECTIONS; d++) begin : g_port
            nx_dist_port #(
                .STREAM_WIDTH (STREAM_WIDTH)
            ) u_port (
                .clk        (clk_i),
                .rst        (rst_i),
                .byp_valid  (bus.bypass_valid_i),
                .byp_hit    (bus.bypass_dir_i == nx_direction_t'(d)),
                .byp_data   (bus.bypass_data_i),
                .emit_valid (bus.emit_valid_i),
                .emit_hit   (bus.emit_dir_i == nx_direction_t'(d)),
                .emit_data  (bus.emit_data_i),
                .out_ready  (bus.dist_ready_i[d]),
                .byp_grant  (w_byp_grant[d]),
                .emit_grant (w_emit_grant[d]),
                .out_data   (bus.dist_data_o[d*STREAM_WIDTH +: STREAM_WIDTH]),
                .out_valid  (bus.dist_valid_o[d])
            );
        end
    endgenerate

    // Only the addressed port can grant, so OR-reduction selects it.
    assign bus.bypass_ready_o = |w_byp_grant;
    assign bus.emit_ready_o   = |w_emit_grant;

    assign idle_o = !(|bus.dist_valid_o) && !bus.bypass_valid_i && !bus.emit_valid_i;

endmodule

`default_nettype wire

// File: tb/tb_nx_msg_distributor.sv
// ============================================================================
// Module   : tb_nx_msg_distributor
// Purpose  : Directed and random stimulus against a message-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nx_msg_distributor;
    import nx_msg_distributor_pkg::*;

    localparam int W = 32;

`ifdef NX_DIST_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic idle;

    nx_msg_distributor_if #(.STREAM_WIDTH(W)) bus();

    nx_msg_distributor #(.STREAM_WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .idle_o (idle),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: what each outbound port currently holds, plus per-port priority.
    logic [3:0]   m_valid;
    logic [W-1:0] m_data [4];
    bit           m_ptr  [4];

    task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit emit_wins(input int d);
        return RR && m_ptr[d];
    endfunction

    task automatic model_clear();
        m_valid = '0;
        for (int d = 0; d < 4; d++) begin
            m_data[d] = '0;
            m_ptr[d]  = 1'b0;
        end
    endtask

    task automatic drive_idle();
        bus.bypass_valid_i = 1'b0;
        bus.bypass_dir_i   = DIRX_NORTH;
        bus.bypass_data_i  = '0;
        bus.emit_valid_i   = 1'b0;
        bus.emit_dir_i     = DIRX_NORTH;
        bus.emit_data_i    = '0;
        bus.dist_ready_i   = 4'h0;
    endtask

    // Apply one cycle of inputs, check the DUT against the model, then advance.
    task automatic step(input bit bv, input int bd, input logic [W-1:0] bdat,
                        input bit ev, input int ed, input logic [W-1:0] edat,
                        input logic [3:0] rdy);
        bit free [4];
        bit exp_br, exp_er;
        bus.bypass_valid_i = bv;
        bus.bypass_dir_i   = nx_direction_t'(bd[1:0]);
        bus.bypass_data_i  = bdat;
        bus.emit_valid_i   = ev;
        bus.emit_dir_i     = nx_direction_t'(ed[1:0]);
        bus.emit_data_i    = edat;
        bus.dist_ready_i   = rdy;
        @(negedge clk);
        for (int d = 0; d < 4; d++) free[d] = !m_valid[d] || rdy[d];
        exp_br = free[bd] && !(ev && ed == bd && emit_wins(bd));
        exp_er = free[ed] && !(bv && bd == ed && !emit_wins(ed));
        chk("dist_valid", bus.dist_valid_o, m_valid);
        for (int d = 0; d < 4; d++) begin
            if (m_valid[d]) chk($sformatf("dist_data[%0d]", d), bus.dist_data_o[d*W +: W], m_data[d]);
        end
        chk("bypass_ready", bus.bypass_ready_o, exp_br);
        chk("emit_ready", bus.emit_ready_o, exp_er);
        chk("idle", idle, !(|m_valid) && !bv && !ev);
        for (int d = 0; d < 4; d++) begin
            if (free[d]) begin
                if (bv && exp_br && bd == d) begin
                    m_data[d] = bdat; m_valid[d] = 1'b1;
                end else if (ev && exp_er && ed == d) begin
                    m_data[d] = edat; m_valid[d] = 1'b1;
                end else begin
                    m_valid[d] = 1'b0;
                end
                if (bv && ev && bd == d && ed == d) m_ptr[d] = !m_ptr[d];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        chk("rst_valid", bus.dist_valid_o, 4'h0);
        chk("rst_data", bus.dist_data_o, '0);
        chk("rst_idle", idle, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // Single route to east
        step(1, 1, 32'hA000_0001, 0, 0, '0, 4'hF);
        step(0, 0, '0, 0, 0, '0, 4'hF);

        // Parallel routes north and west
        step(1, 0, 32'hD000_0000, 1, 3, 32'hD000_0001, 4'hF);
        step(0, 0, '0, 0, 0, '0, 4'hF);

        // Conflict on south for 4 cycles
        for (int i = 0; i < 4; i++)
            step(1, 2, 32'hB000_0000 + i, 1, 2, 32'hE000_0000 + i, 4'hF);
        step(0, 0, '0, 0, 0, '0, 4'hF);

        // Backpressure on north while east keeps flowing
        step(1, 0, 32'h1111_1111, 0, 0, '0, 4'hF);
        for (int i = 0; i < 5; i++)
            step(1, i % 2, 32'h2000_0000 + i, 0, 0, '0, 4'hE);
        step(1, 0, 32'h3333_3333, 0, 0, '0, 4'hF);
        step(0, 0, '0, 0, 0, '0, 4'hF);

        // Streaming to west
        for (int i = 0; i < 16; i++)
            step(1, 3, 32'h5000_0000 + i, 0, 0, '0, 4'hF);
        step(0, 0, '0, 0, 0, '0, 4'hF);

        // Reset with three ports held, then a conflict must favour bypass
        step(1, 0, 32'h6000_0000, 1, 1, 32'h6000_0001, 4'h0);
        step(1, 2, 32'h6000_0002, 0, 0, '0, 4'h0);
        pulse_reset();
        step(1, 2, 32'h7000_0000, 1, 2, 32'h7000_0001, 4'hF);
        step(0, 0, '0, 0, 0, '0, 4'hF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom(),
                 4'($urandom_range(0, 15) | $urandom_range(0, 15)));
        end
        step(0, 0, '0, 0, 0, '0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
